// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Instruction-fetch stage with an IF/ID pipeline register. It accepts one
//   fetch address per transaction from the PC stage, issues a single-word read
//   to instruction memory, and waits out any busywait cycles. The returned word
//   is then either delivered to IF/ID or parked in a hold register while the
//   hazard unit stalls. A taken branch or jump (FLUSH) kills whatever is in
//   flight or held, and bubbles the IF/ID register.
//
// Ports:
//   CLK            in   1   clock; all state updates on the rising edge
//   RESET          in   1   asynchronous, active-high reset
//   PC_IN          in  32   fetch address offered by the PC stage
//   PC_STALL       out  1   1 = PC stage must hold PC_IN; 0 only on accept
//   STALL          in   1   hazard-unit stall; freezes the IF/ID outputs
//   FLUSH          in   1   branch/jump taken; kills in-flight/held work
//   IMEM_READ      out  1   instruction-memory read request
//   IMEM_ADDR      out 30   word address (PC[31:2]) of the accepted fetch
//   IMEM_READDATA  in  32   instruction word, valid when IMEM_BUSYWAIT is low
//   IMEM_BUSYWAIT  in   1   memory not ready
//   INSTR_OUT      out 32   IF/ID instruction
//   PC_OUT         out 32   IF/ID fetch address
//   PC4_OUT        out 32   IF/ID fetch address + 4 (wraps modulo 2^32)
//   VALID_OUT      out  1   IF/ID holds a real pipeline entry
//   MISALIGN_OUT   out  1   IF/ID entry came from a PC with PC[1:0] != 0
//------------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] PC_IN,
   output logic        PC_STALL,
   input  logic        STALL,
   input  logic        FLUSH,
   output logic        IMEM_READ,
   output logic [29:0] IMEM_ADDR,
   input  logic [31:0] IMEM_READDATA,
   input  logic        IMEM_BUSYWAIT,
   output logic [31:0] INSTR_OUT,
   output logic [31:0] PC_OUT,
   output logic [31:0] PC4_OUT,
   output logic        VALID_OUT,
   output logic        MISALIGN_OUT
);

   // FSM encoding
   localparam logic [1:0] IDLE = 2'd0;  // ready to accept a new PC
   localparam logic [1:0] WAIT = 2'd1;  // memory read outstanding
   localparam logic [1:0] HOLD = 2'd2;  // word parked, waiting for STALL=0

   //---------------------------------------------------------------------------
   // Fetch-side state
   //---------------------------------------------------------------------------
   logic [1:0]  state_reg,         state_next;
   logic [31:0] addr_reg,          addr_next;
   logic [31:0] hold_instr_reg,    hold_instr_next;
   logic        hold_misalign_reg, hold_misalign_next;
   logic        kill_reg,          kill_next;

   //---------------------------------------------------------------------------
   // IF/ID pipeline register
   //---------------------------------------------------------------------------
   logic [31:0] instr_reg,    instr_next;
   logic [31:0] pc_reg,       pc_next;
   logic [31:0] pc4_reg,      pc4_next;
   logic        valid_reg,    valid_next;
   logic        misalign_reg, misalign_next;

   // Delivery request from the FSM to the IF/ID register for this edge.
   logic        load_en;
   logic [31:0] load_instr;
   logic        load_misalign;

   logic        pc_in_misaligned;
   logic        accept;

   assign pc_in_misaligned = (PC_IN[1:0] != 2'b00);
   assign accept           = (state_reg == IDLE) && !STALL && !FLUSH;

   //---------------------------------------------------------------------------
   // Combinational outputs toward the PC stage and the memory
   //---------------------------------------------------------------------------
   // Outside IDLE the unit is busy with one transaction, so the PC stage is
   // always held. In IDLE the PC is consumed exactly when it is accepted.
   assign PC_STALL  = (state_reg == IDLE) ? (STALL | FLUSH) : 1'b1;

   // The request is a pure function of the state and the latched address, so
   // it stays stable for the whole access and drops the cycle after
   // completion (or immediately on reset).
   assign IMEM_READ = (state_reg == WAIT);
   assign IMEM_ADDR = addr_reg[31:2];

   //---------------------------------------------------------------------------
   // FSM next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_next         = state_reg;
      addr_next          = addr_reg;
      hold_instr_next    = hold_instr_reg;
      hold_misalign_next = hold_misalign_reg;
      kill_next          = kill_reg;
      load_en            = 1'b0;
      load_instr         = hold_instr_reg;
      load_misalign      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               addr_next = PC_IN;
               if (pc_in_misaligned) begin
                  // No memory access for a misaligned PC: park a NOP tagged
                  // as misaligned and deliver it through the HOLD path, so
                  // it reaches IF/ID with the same timing as a real fetch.
                  hold_instr_next    = NOP_INSTR;
                  hold_misalign_next = 1'b1;
                  state_next         = HOLD;
               end else begin
                  kill_next  = 1'b0;
                  state_next = WAIT;
               end
            end
         end

         WAIT: begin
            // A flush cannot abort the memory access, so it is remembered
            // and the returning word is thrown away.
            if (FLUSH) begin
               kill_next = 1'b1;
            end
            if (!IMEM_BUSYWAIT) begin
               kill_next = 1'b0;
               if (kill_reg || FLUSH) begin
                  state_next = IDLE;
               end else if (STALL) begin
                  hold_instr_next    = IMEM_READDATA;
                  hold_misalign_next = 1'b0;
                  state_next         = HOLD;
               end else begin
                  load_en       = 1'b1;
                  load_instr    = IMEM_READDATA;
                  load_misalign = 1'b0;
                  state_next    = IDLE;
               end
            end
         end

         HOLD: begin
            if (FLUSH) begin
               state_next = IDLE;
            end else if (!STALL) begin
               load_en       = 1'b1;
               load_instr    = hold_instr_reg;
               load_misalign = hold_misalign_reg;
               state_next    = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
            kill_next  = 1'b0;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // IF/ID next-value logic
   //---------------------------------------------------------------------------
   // Priority: FLUSH bubble > new delivery > STALL freeze > plain bubble.
   // When nothing new arrives and decode is not stalled, VALID/MISALIGN drop
   // so the previous entry is not consumed twice; the instruction and PC
   // fields simply keep their last values.
   always_comb begin
      instr_next    = instr_reg;
      pc_next       = pc_reg;
      pc4_next      = pc4_reg;
      valid_next    = valid_reg;
      misalign_next = misalign_reg;

      if (FLUSH) begin
         instr_next    = NOP_INSTR;
         valid_next    = 1'b0;
         misalign_next = 1'b0;
      end else if (load_en) begin
         // A misaligned entry is marked valid so that it travels down the
         // pipeline and can raise the address-misaligned exception there.
         instr_next    = load_instr;
         pc_next       = addr_reg;
         pc4_next      = addr_reg + 32'd4;
         valid_next    = 1'b1;
         misalign_next = load_misalign;
      end else if (!STALL) begin
         valid_next    = 1'b0;
         misalign_next = 1'b0;
      end
   end

   //---------------------------------------------------------------------------
   // State registers
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg         <= IDLE;
         addr_reg          <= 32'd0;
         hold_instr_reg    <= NOP_INSTR;
         hold_misalign_reg <= 1'b0;
         kill_reg          <= 1'b0;
      end else begin
         state_reg         <= state_next;
         addr_reg          <= addr_next;
         hold_instr_reg    <= hold_instr_next;
         hold_misalign_reg <= hold_misalign_next;
         kill_reg          <= kill_next;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         instr_reg    <= NOP_INSTR;
         pc_reg       <= 32'd0;
         pc4_reg      <= 32'd0;
         valid_reg    <= 1'b0;
         misalign_reg <= 1'b0;
      end else begin
         instr_reg    <= instr_next;
         pc_reg       <= pc_next;
         pc4_reg      <= pc4_next;
         valid_reg    <= valid_next;
         misalign_reg <= misalign_next;
      end
   end

   assign INSTR_OUT    = instr_reg;
   assign PC_OUT       = pc_reg;
   assign PC4_OUT      = pc4_reg;
   assign VALID_OUT    = valid_reg;
   assign MISALIGN_OUT = misalign_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Purpose:
//   Self-checking bench for instr_fetch_unit. A transaction-level reference
//   model (one fetch in flight, one word held, kill flag) predicts the IF/ID
//   contents and the PC/memory handshake each cycle. Directed sequences cover
//   the zero-wait, busywait, stall, flush, misaligned and wrap cases, followed
//   by randomized traffic with occasional asynchronous resets.
//------------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_stall;
   logic        stall;
   logic        flush;
   logic        imem_read;
   logic [29:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        busy;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic [31:0] pc4_out;
   logic        valid_out;
   logic        misalign_out;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.NOP_INSTR(NOP)) dut (
      .CLK           (clk),
      .RESET         (rst),
      .PC_IN         (pc_in),
      .PC_STALL      (pc_stall),
      .STALL         (stall),
      .FLUSH         (flush),
      .IMEM_READ     (imem_read),
      .IMEM_ADDR     (imem_addr),
      .IMEM_READDATA (imem_rdata),
      .IMEM_BUSYWAIT (busy),
      .INSTR_OUT     (instr_out),
      .PC_OUT        (pc_out),
      .PC4_OUT       (pc4_out),
      .VALID_OUT     (valid_out),
      .MISALIGN_OUT  (misalign_out)
   );

   // Instruction memory contents: a fixed word at address 0, a hash elsewhere.
   function automatic logic [31:0] mem_word(input logic [29:0] w);
      if (w == 30'd0) return 32'h00500093;
      return ({2'b00, w} * 32'h9E3779B1) ^ 32'h00000033;
   endfunction

   // Garbage while busy so an early capture is visible.
   assign imem_rdata = busy ? 32'hDEADBEEF : mem_word(imem_addr);

   //---------------------------------------------------------------------------
   // Reference model
   //---------------------------------------------------------------------------
   bit          m_fetching;   // a read is outstanding
   bit          m_killed;     // outstanding read must be discarded
   bit          m_holding;    // a word waits for the stall to release
   logic [31:0] m_fpc;
   logic [31:0] m_held_word;
   logic [31:0] m_held_pc;
   bit          m_held_mis;
   logic [31:0] exp_instr, exp_pc, exp_pc4;
   bit          exp_valid, exp_mis;

   task automatic check_eq(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fetching = 0; m_killed = 0; m_holding = 0;
      m_fpc = 0; m_held_word = NOP; m_held_pc = 0; m_held_mis = 0;
      exp_instr = NOP; exp_pc = 0; exp_pc4 = 0; exp_valid = 0; exp_mis = 0;
   endtask

   // Apply one clock edge to the model using the currently driven inputs.
   task automatic model_edge();
      bit          dlv = 0;
      logic [31:0] d_word = 0;
      logic [31:0] d_pc = 0;
      bit          d_mis = 0;
      if (m_fetching) begin
         if (!busy) begin
            m_fetching = 0;
            if (m_killed || flush) begin
               m_killed = 0;
            end else if (stall) begin
               m_holding   = 1;
               m_held_word = mem_word(m_fpc[31:2]);
               m_held_pc   = m_fpc;
               m_held_mis  = 0;
            end else begin
               dlv = 1; d_word = mem_word(m_fpc[31:2]); d_pc = m_fpc; d_mis = 0;
            end
         end else if (flush) begin
            m_killed = 1;
         end
      end else if (m_holding) begin
         if (flush) begin
            m_holding = 0;
         end else if (!stall) begin
            dlv = 1; d_word = m_held_word; d_pc = m_held_pc; d_mis = m_held_mis;
            m_holding = 0;
         end
      end else if (!stall && !flush) begin
         if (pc_in[1:0] != 2'b00) begin
            m_holding = 1; m_held_word = NOP; m_held_pc = pc_in; m_held_mis = 1;
         end else begin
            m_fetching = 1; m_fpc = pc_in; m_killed = 0;
         end
      end

      if (flush) begin
         exp_instr = NOP; exp_valid = 0; exp_mis = 0;
      end else if (dlv) begin
         exp_instr = d_word; exp_pc = d_pc; exp_pc4 = d_pc + 32'd4;
         exp_valid = 1; exp_mis = d_mis;
         $display("[TB] deliver pc=%h instr=%h misalign=%0d", d_pc, d_word, d_mis);
      end else if (!stall) begin
         exp_valid = 0; exp_mis = 0;
      end
   endtask

   task automatic check_comb();
      check_eq("imem_read", imem_read, m_fetching);
      check_eq("pc_stall", pc_stall, m_fetching || m_holding || stall || flush);
      if (m_fetching) check_eq("imem_addr", imem_addr, m_fpc[31:2]);
   endtask

   task automatic check_regs();
      check_eq("instr_out", instr_out, exp_instr);
      check_eq("pc_out", pc_out, exp_pc);
      check_eq("pc4_out", pc4_out, exp_pc4);
      check_eq("valid_out", valid_out, exp_valid);
      check_eq("misalign_out", misalign_out, exp_mis);
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_instr"}, instr_out, NOP);
      check_eq({tag, "_pc"}, pc_out, 32'd0);
      check_eq({tag, "_pc4"}, pc4_out, 32'd0);
      check_eq({tag, "_valid"}, valid_out, 1'b0);
      check_eq({tag, "_mis"}, misalign_out, 1'b0);
      check_eq({tag, "_read"}, imem_read, 1'b0);
      check_eq({tag, "_addr"}, imem_addr, 30'd0);
   endtask

   // One cycle: entered just after a falling edge.
   task automatic step(input bit s, input bit f, input bit b, input logic [31:0] p);
      stall = s; flush = f; busy = b; pc_in = p;
      #1;
      check_comb();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_regs();
   endtask

   initial begin
      logic [31:0] rnd;
      logic [31:0] p;
      rst = 1'b1; stall = 0; flush = 0; busy = 0; pc_in = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      // Zero-wait fetch at PC 0
      step(0, 0, 0, 32'h0);
      step(0, 0, 0, 32'h0);
      check_eq("zw_instr", instr_out, 32'h00500093);
      check_eq("zw_pc4", pc4_out, 32'd4);
      // Busywait: 3 busy cycles at PC 0x10
      step(0, 0, 0, 32'h10);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h10);
      step(0, 0, 0, 32'h10);
      // Stall at completion for 2 cycles
      step(0, 0, 0, 32'h14);
      step(1, 0, 0, 32'h14);
      step(1, 0, 0, 32'h14);
      step(0, 0, 0, 32'h14);
      // Flush during WAIT for PC 0x20, then new PC 0x30
      step(0, 0, 0, 32'h20);
      step(0, 1, 1, 32'h20);
      step(0, 0, 0, 32'h30);
      step(0, 0, 0, 32'h30);
      step(0, 0, 0, 32'h30);
      check_eq("flush_newpc", pc_out, 32'h30);
      // Misaligned PC 6
      step(0, 0, 0, 32'h6);
      step(0, 0, 0, 32'h6);
      check_eq("mis_flag", misalign_out, 1'b1);
      check_eq("mis_pc", pc_out, 32'h6);
      // PC4 wrap
      step(0, 0, 0, 32'hFFFFFFFC);
      step(0, 0, 0, 32'h0);
      check_eq("wrap_pc4", pc4_out, 32'h0);

      // Randomized traffic with periodic asynchronous resets
      for (int c = 0; c < 1500; c++) begin
         if (c % 250 == 125) begin
            // Start a fetch, leave it busy, then reset between edges.
            step(0, 0, 0, 32'h40);
            stall = 0; flush = 0; busy = 1; pc_in = 32'h40;
            #3 rst = 1'b1;
            #1 check_reset_state("async_reset");
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            busy = 0;
            model_reset();
         end
         rnd = $urandom;
         case ($urandom_range(0, 9))
            0:       p = {rnd[31:2], 2'b01 + 2'($urandom_range(0, 2))};
            1:       p = 32'hFFFFFFFC;
            default: p = {rnd[31:2], 2'b00};
         endcase
         step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) == 0, p);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
